// File: rtl/seg_status_ctrl_pkg.sv
// Shared definitions for the status-to-7-segment controller: state codes,
// display glyphs and width helpers.
package seg_status_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RST   = 3'd0,
    ST_SLEEP = 3'd1,
    ST_LIGHT = 3'd2,
    ST_DRAW  = 3'd3,
    ST_WRITE = 3'd4,
    ST_ERASE = 3'd5,
    ST_COLOR = 3'd6,
    ST_STOP  = 3'd7
  } st_state_e;

  typedef enum logic {
    PH_OFF = 1'b0,
    PH_ON  = 1'b1
  } blink_phase_e;

  localparam logic [3:0] GLYPH_EIGHT = 4'h8;
  localparam logic [3:0] GLYPH_SLEEP = 4'hA;
  localparam logic [3:0] GLYPH_ERR   = 4'hF;
  localparam logic [3:0] GLYPH_BLANK = 4'h0;

  localparam int CLOCK_FREQ = 50_000_000;

  // Counter width able to hold 0..v-1, never narrower than one bit.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/seg_status_ctrl_blink_timer.sv
// Blink engine: half-period tick counter, ON/OFF phase and a finite
// period count that ends in a steady-ON state with a one-cycle done pulse.
//
//   phase  | meaning
//   -------+-------------------------------------------------------------
//   PH_ON  | digits lit; entered on clear and on every OFF->ON wrap
//   PH_OFF | digits dark; entered on every ON->OFF wrap
//   steady | terminal flag: count reached BLINK_CYCLES, timer frozen in ON
//
// Outputs carry next-state values so the parent's registered outputs line
// up with the timer state without an extra cycle of latency.
module blink_timer
  import seg_status_ctrl_pkg::*;
#(
  parameter int HALF         = 4,
  parameter int BLINK_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clear,
  input  logic         i_run,
  input  logic         i_endless,
  output blink_phase_e o_phase,
  output logic         o_done_pulse,
  output logic         o_steady
);

  localparam int TICK_W = clog2_min1(HALF);
  localparam int CNT_W  = clog2_min1(BLINK_CYCLES + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(HALF - 1);
  localparam logic [CNT_W-1:0]  CNT_DONE  = CNT_W'(BLINK_CYCLES);

  logic [TICK_W-1:0] r_tick;
  logic [CNT_W-1:0]  r_cnt;
  blink_phase_e      r_phase;
  logic              r_steady;

  logic [TICK_W-1:0] w_tick_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  blink_phase_e      w_phase_nxt;
  logic              w_steady_nxt;
  logic              w_done_nxt;

  always_comb begin
    w_tick_nxt   = r_tick;
    w_cnt_nxt    = r_cnt;
    w_phase_nxt  = r_phase;
    w_steady_nxt = r_steady;
    w_done_nxt   = 1'b0;
    if (i_clear) begin
      w_tick_nxt  = '0;
      w_cnt_nxt   = '0;
      w_phase_nxt = PH_ON;
      w_steady_nxt = 1'b0;
      // A zero-length blink sequence completes on the entry cycle itself.
      if (i_run && !i_endless && (BLINK_CYCLES == 0)) begin
        w_steady_nxt = 1'b1;
        w_done_nxt   = 1'b1;
      end
    end else if (i_run && !r_steady) begin
      if (r_tick == TICK_LAST) begin
        w_tick_nxt = '0;
        if (r_phase == PH_ON) begin
          w_phase_nxt = PH_OFF;
        end else begin
          w_phase_nxt = PH_ON;
          if (!i_endless) begin
            w_cnt_nxt = r_cnt + 1'b1;
            if (w_cnt_nxt == CNT_DONE) begin
              w_steady_nxt = 1'b1;
              w_done_nxt   = 1'b1;
            end
          end
        end
      end else begin
        w_tick_nxt = r_tick + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick   <= '0;
      r_cnt    <= '0;
      r_phase  <= PH_ON;
      r_steady <= 1'b0;
    end else begin
      r_tick   <= w_tick_nxt;
      r_cnt    <= w_cnt_nxt;
      r_phase  <= w_phase_nxt;
      r_steady <= w_steady_nxt;
    end
  end

  assign o_phase      = w_phase_nxt;
  assign o_done_pulse = w_done_nxt;
  assign o_steady     = w_steady_nxt;

endmodule

// File: rtl/seg_status_ctrl.sv
// Maps the system state code onto 7-segment digit nibbles and enables for
// hex_display, with a blink sequence on RST and endless blink on bad codes.
module seg_status_ctrl
  import seg_status_ctrl_pkg::*;
#(
  parameter int N_DIGITS     = 8,
  parameter int STATE_W      = 3,
  parameter int CLK_HZ       = CLOCK_FREQ,
  parameter int BLINK_HZ     = 2,
  parameter int BLINK_CYCLES = 2,
  localparam int DATA_W      = 4 * N_DIGITS,
  localparam int VAL_W       = (N_DIGITS > 2) ? 4 * (N_DIGITS - 2) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [STATE_W-1:0]  state_i,
  input  logic [VAL_W-1:0]    value_i,
  output logic [DATA_W-1:0]   data_o,
  output logic [N_DIGITS-1:0] en_o,
  output logic                blink_done_o
);

  localparam int HALF = (BLINK_HZ > 0) ? CLK_HZ / (2 * BLINK_HZ) : 0;

  if (HALF < 1) begin : g_bad_half
    $error("seg_status_ctrl: blink half-period CLK_HZ/(2*BLINK_HZ) must be >= 1");
  end
  if (STATE_W < 3) begin : g_bad_state_w
    $error("seg_status_ctrl: STATE_W must be >= 3");
  end

  logic [STATE_W-1:0]  r_state_q;
  logic                r_first;
  logic [DATA_W-1:0]   r_data;
  logic [N_DIGITS-1:0] r_en;
  logic                r_done;

  logic                w_change;
  logic [31:0]         w_state_ext;
  logic                w_illegal;
  st_state_e           w_code;
  logic                w_run;
  blink_phase_e        w_phase;
  logic                w_blink_done;
  logic                w_steady;
  logic [DATA_W-1:0]   w_val_pad;
  logic [DATA_W-1:0]   w_data_nxt;
  logic [N_DIGITS-1:0] w_en_nxt;
  logic                w_done_nxt;

  assign w_change    = r_first || (state_i != r_state_q);
  assign w_state_ext = 32'(state_i);
  assign w_illegal   = (w_state_ext > 32'd7);
  assign w_code      = st_state_e'(w_state_ext[2:0]);
  assign w_run       = w_illegal || (w_code == ST_RST);
  assign w_val_pad   = DATA_W'(value_i);

  blink_timer #(
    .HALF         (HALF),
    .BLINK_CYCLES (BLINK_CYCLES)
  ) u_blink_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clear      (w_change),
    .i_run        (w_run),
    .i_endless    (w_illegal),
    .o_phase      (w_phase),
    .o_done_pulse (w_blink_done),
    .o_steady     (w_steady)
  );

  always_comb begin
    w_data_nxt = '0;
    w_en_nxt   = '0;
    w_done_nxt = 1'b0;
    if (w_illegal) begin
      w_data_nxt = {N_DIGITS{GLYPH_ERR}};
      w_en_nxt   = (w_phase == PH_ON) ? '1 : '0;
    end else begin
      case (w_code)
        ST_RST: begin
          w_data_nxt = {N_DIGITS{GLYPH_EIGHT}};
          w_en_nxt   = (w_steady || (w_phase == PH_ON)) ? '1 : '0;
          w_done_nxt = w_blink_done;
        end
        ST_SLEEP: begin
          // Top three digits; on narrow displays this covers every digit.
          for (int d = 0; d < N_DIGITS; d++) begin
            if (d >= N_DIGITS - 3) begin
              w_data_nxt[4*d +: 4] = GLYPH_SLEEP;
              w_en_nxt[d]          = 1'b1;
            end
          end
        end
        default: begin
          for (int d = 0; d < N_DIGITS; d++) begin
            if (d == N_DIGITS - 1) begin
              w_data_nxt[4*d +: 4] = {1'b0, w_code};
              w_en_nxt[d]          = 1'b1;
            end else if (d == N_DIGITS - 2) begin
              w_data_nxt[4*d +: 4] = GLYPH_BLANK;
              w_en_nxt[d]          = 1'b0;
            end else begin
              w_data_nxt[4*d +: 4] = w_val_pad[4*d +: 4];
              w_en_nxt[d]          = 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q <= '0;
      r_first   <= 1'b1;
      r_data    <= '0;
      r_en      <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state_q <= state_i;
      r_first   <= 1'b0;
      r_data    <= w_data_nxt;
      r_en      <= w_en_nxt;
      r_done    <= w_done_nxt;
    end
  end

  assign data_o       = r_data;
  assign en_o         = r_en;
  assign blink_done_o = r_done;

endmodule

// File: doc/seg_status_ctrl.md
Name: seg_status_ctrl

Overview:
- Parametrised status-to-7-segment controller.
- Maps the system state code from the st controller to a digit word and a per-digit enable mask for hex_display.
- Adds a programmable blink engine: finite blink count with a completion pulse, and endless blink for illegal states.
- Replaces the hard-coded, partly unreachable state/blink case logic in the top level. Sits between st and hex_display.

Parameters:
- N_DIGITS, 8: number of 7-segment digits; data width is 4*N_DIGITS.
- STATE_W, 3: width of the state code.
- CLK_HZ, 50_000_000: clk frequency.
- BLINK_HZ, 2: blink frequency; half-period HALF = CLK_HZ/(2*BLINK_HZ). Elaboration error if HALF < 1.
- BLINK_CYCLES, 2: full on/off periods shown in RST before holding steady. 0 = no blink.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- state_i  in  STATE_W  current system state code (RST=0, SLEEP=1, LIGHT=2, DRAW=3, WRITE=4, ERASE=5, COLOR=6, STOP=7)
- value_i  in  4*(N_DIGITS-2)  auxiliary hex value shown in working states
- data_o  out  4*N_DIGITS  digit nibbles to hex_display; digit 0 = LSB nibble
- en_o  out  N_DIGITS  per-digit enable; 1 = lit
- blink_done_o  out  1  one-cycle pulse when the RST blink sequence completes

Behaviour:
- Reset: data_o=0, en_o=0, blink_done_o=0, tick counter=0, phase=ON, cycle count=0, steady=0, first=1.
- Change detection: register state_q. A change is (state_i != state_q) or first=1.
  - On a change: tick=0, phase=ON, cycle count=0, steady=0, first cleared.
  - Outputs reflect the new state in the following cycle. Latency is 1 clk; all outputs are registered.
- Blink timer:
  - Tick counts 0..HALF-1. On wrap, phase toggles.
  - On an OFF->ON toggle, the cycle count increments.
  - A change in the same cycle as a wrap: the change wins, no toggle.
- Per-state mapping:
  - RST: data all 4'h8.
    - While not steady: en = phase ? all 1 : all 0.
    - When the cycle count reaches BLINK_CYCLES (on that OFF->ON wrap): set steady, en all 1, blink_done_o=1 for exactly that cycle.
    - BLINK_CYCLES=0: steady and done pulse in the first output cycle after the change.
    - Timer is frozen once steady.
  - SLEEP: top 3 digits = 4'hA, en only on those 3 digits, no blink. If N_DIGITS < 3, all digits.
  - LIGHT..STOP: digit N-1 = state code (zero-extended), digit N-2 blank (en 0), digits N-3..0 = value_i, no blink.
  - Illegal code (only possible if STATE_W > 3): data all 4'hF, blink forever at BLINK_HZ, no done pulse.
- value_i is sampled every cycle in working states, so display updates with 1-cycle latency.
- Reset asserted mid-blink aborts everything to reset values. After release, the first cycle is treated as a change.
- blink_done_o never fires outside RST. It fires at most once per entry into RST.

Decomposition:
- Shared header/package: state codes (replacing the st_state macros), glyph constants GLYPH_EIGHT=4'h8, GLYPH_SLEEP=4'hA, GLYPH_ERR=4'hF, and the CLOCK_FREQ default.
- Sub-module blink_timer (parameters HALF, BLINK_CYCLES).
  - Inputs: clear, run.
  - Outputs: phase, done_pulse, steady.
- seg_status_ctrl holds the change detection and the mapping.

Test Plan:
All scenarios use CLK_HZ=8, BLINK_HZ=1 (HALF=4), BLINK_CYCLES=2, N_DIGITS=8.
1. Reset release with state_i=0 -> from cycle 1: data_o=32'h8888_8888. en_o sequence is FF for 4 cycles, 00 for 4, FF for 4, 00 for 4, then FF held. blink_done_o=1 only in the first steady cycle (cycle 17).
2. state_i 0->1 at cycle 6 (mid-OFF) -> next cycle data_o=32'hAAAx_xxxx with en_o=8'hE0, constant. Re-entering 0 restarts the blink from ON and produces another done pulse.
3. state_i=3, value_i=24'h00_12AB -> data_o[31:28]=4'h3, en_o=8'hBF, data_o[23:0]=24'h0012AB. Changing value_i to 24'hFFFFFF appears 1 cycle later.
4. STATE_W=4 build, state_i=4'h9 -> data_o=32'hFFFF_FFFF, en_o toggles FF/00 every 4 cycles indefinitely (observe 40 cycles), no done pulse.
5. rst_n low for 2 cycles during the second ON phase of RST -> all outputs 0 during reset. After release, the sequence restarts as in scenario 1.
6. BLINK_CYCLES=0 build, state_i=0 -> en_o=8'hFF from the first output cycle, single done pulse in that cycle, no toggling afterwards.
